// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: sequential instruction fetcher with prefetch FIFO, valid/ready delivery and jump flush.
// Optional macro IFU_MISALIGN_CHECK_EN adds misaligned jump-target detection with a HALT state.
//
// state | meaning
// IDLE  | just out of reset, no requests
// RUN   | issuing sequential fetches and delivering instructions
// HALT  | stopped after a misaligned jump, waits for an aligned jump
module inst_fetch_unit #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = '0,
  parameter int                DEPTH     = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  output logic              RomReadEnableOut,
  output logic [ADDR_W-1:0] RomReadAddrOut,
  input  logic [31:0]       RomReadDataIn,
  input  logic              RomReadyIn,
  input  logic              JumpFlagIn,
  input  logic [ADDR_W-1:0] JumpAddrIn,
  output logic              InstValidOut,
  output logic [31:0]       InstOut,
  output logic [ADDR_W-1:0] InstAddrOut,
  input  logic              InstReadyIn,
  output logic              AddrMisalignOut
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              pending_q;
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     count_q;
  logic [31:0]       fifo_inst [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];

  logic [CW:0] occupied;
  logic        jump, misalign_jump, issue, push, pop;

  assign jump = JumpFlagIn & (state_q != IDLE);

`ifdef IFU_MISALIGN_CHECK_EN
  assign misalign_jump = jump & (JumpAddrIn[1:0] != 2'b00);
`else
  assign misalign_jump = 1'b0;
`endif

  // In-flight request counts against capacity so the FIFO can never overflow
  assign occupied = {1'b0, count_q} + {{CW{1'b0}}, pending_q};
  assign issue    = (state_q == RUN) & ~JumpFlagIn & (occupied < DEPTH_V);
  assign push     = pending_q & RomReadyIn & ~JumpFlagIn;
  assign pop      = InstValidOut & InstReadyIn & ~JumpFlagIn;

  assign RomReadEnableOut = issue;
  assign RomReadAddrOut   = pc_q;
  assign InstValidOut     = (count_q != '0);
  assign InstOut          = InstValidOut ? fifo_inst[rd_ptr_q] : 32'h0;
  assign InstAddrOut      = InstValidOut ? fifo_pc[rd_ptr_q] : '0;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = RUN;
      RUN:  if (misalign_jump) state_d = HALT;
      HALT: if (jump && !misalign_jump) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc_q      <= BOOT_ADDR;
      req_pc_q  <= '0;
      pending_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else if (jump) begin
      pc_q      <= JumpAddrIn;
      pending_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= issue;
      if (issue) begin
        pc_q     <= pc_q + ADDR_W'(4);
        req_pc_q <= pc_q;
      end
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (!push && pop) count_q <= count_q - CW'(1);
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_inst[wr_ptr_q] <= RomReadDataIn;
      fifo_pc[wr_ptr_q]   <= req_pc_q;
    end
  end

`ifdef IFU_MISALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)      misalign_q <= 1'b0;
    else if (jump) misalign_q <= misalign_jump;
  end

  assign AddrMisalignOut = misalign_q;
`else
  assign AddrMisalignOut = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit with a one-cycle-latency ROM responder.
// Define IFU_MISALIGN_CHECK_EN for both files to exercise the misalignment path.
module tb_inst_fetch_unit;

  logic        Clk;
  logic        Rst;
  logic        RomReadEnableOut;
  logic [63:0] RomReadAddrOut;
  logic [31:0] RomReadDataIn;
  logic        RomReadyIn;
  logic        JumpFlagIn;
  logic [63:0] JumpAddrIn;
  logic        InstValidOut;
  logic [31:0] InstOut;
  logic [63:0] InstAddrOut;
  logic        InstReadyIn;
  logic        AddrMisalignOut;

  int vecs = 0;
  int errs = 0;

  logic        req_s;
  logic [63:0] addr_s;

  inst_fetch_unit dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .RomReadEnableOut (RomReadEnableOut),
    .RomReadAddrOut   (RomReadAddrOut),
    .RomReadDataIn    (RomReadDataIn),
    .RomReadyIn       (RomReadyIn),
    .JumpFlagIn       (JumpFlagIn),
    .JumpAddrIn       (JumpAddrIn),
    .InstValidOut     (InstValidOut),
    .InstOut          (InstOut),
    .InstAddrOut      (InstAddrOut),
    .InstReadyIn      (InstReadyIn),
    .AddrMisalignOut  (AddrMisalignOut)
  );

  function automatic logic [31:0] rom_word(input logic [63:0] a);
    return a[31:0] ^ 32'hDEAD_0000;
  endfunction

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // ROM: answers the request seen in one cycle during the following cycle
  initial begin
    RomReadyIn    = 1'b0;
    RomReadDataIn = 32'h0;
    forever begin
      @(negedge Clk);
      req_s  = RomReadEnableOut;
      addr_s = RomReadAddrOut;
      @(posedge Clk);
      #1;
      RomReadyIn    = req_s;
      RomReadDataIn = req_s ? rom_word(addr_s) : 32'h0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic test_reset;
    Rst = 1'b0; JumpFlagIn = 1'b0; JumpAddrIn = 64'h0; InstReadyIn = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    vecs++; if (RomReadEnableOut !== 1'b0) begin errs++; $display("FAIL rst_en: got %b want 0", RomReadEnableOut); end
    vecs++; if (RomReadAddrOut !== 64'h0) begin errs++; $display("FAIL rst_addr: got %h want 0", RomReadAddrOut); end
    vecs++; if (InstValidOut !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", InstValidOut); end
    vecs++; if (InstOut !== 32'h0) begin errs++; $display("FAIL rst_inst: got %h want 0", InstOut); end
    vecs++; if (InstAddrOut !== 64'h0) begin errs++; $display("FAIL rst_pc: got %h want 0", InstAddrOut); end
    vecs++; if (AddrMisalignOut !== 1'b0) begin errs++; $display("FAIL rst_misalign: got %b want 0", AddrMisalignOut); end
  endtask

  task automatic test_boot;
    Rst = 1'b1;
    #1;
    vecs++; if (RomReadEnableOut !== 1'b0) begin errs++; $display("FAIL boot_idle_en: got %b want 0", RomReadEnableOut); end
    @(posedge Clk);
    @(negedge Clk);
    vecs++; if (RomReadEnableOut !== 1'b1 || RomReadAddrOut !== 64'h0) begin errs++; $display("FAIL boot_req0: got en=%b addr=%h want en=1 addr=0", RomReadEnableOut, RomReadAddrOut); end
    vecs++; if (InstValidOut !== 1'b0) begin errs++; $display("FAIL boot_valid_c1: got %b want 0", InstValidOut); end
    @(negedge Clk);
    vecs++; if (RomReadEnableOut !== 1'b1 || RomReadAddrOut !== 64'h4) begin errs++; $display("FAIL boot_req1: got en=%b addr=%h want en=1 addr=4", RomReadEnableOut, RomReadAddrOut); end
    vecs++; if (InstValidOut !== 1'b0) begin errs++; $display("FAIL boot_valid_c2: got %b want 0", InstValidOut); end
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      vecs++;
      if (InstValidOut !== 1'b1 || InstAddrOut !== 64'(4 * i) || InstOut !== rom_word(64'(4 * i))) begin
        errs++;
        $display("FAIL boot_inst%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", i, InstValidOut, InstAddrOut, InstOut, 64'(4 * i), rom_word(64'(4 * i)));
      end
    end
  endtask

  task automatic test_backpressure;
    int n_en;
    n_en = 0;
    InstReadyIn = 1'b0;
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (RomReadEnableOut) n_en++;
    end
    vecs++; if (n_en !== 4) begin errs++; $display("FAIL bp_requests: got %0d want 4", n_en); end
    vecs++; if (RomReadEnableOut !== 1'b0) begin errs++; $display("FAIL bp_full_en: got %b want 0", RomReadEnableOut); end
    vecs++; if (InstValidOut !== 1'b1 || InstAddrOut !== 64'h0) begin errs++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0", InstValidOut, InstAddrOut); end
    @(posedge Clk);
    #1 InstReadyIn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      vecs++;
      if (InstValidOut !== 1'b1 || InstAddrOut !== 64'(4 * i) || InstOut !== rom_word(64'(4 * i))) begin
        errs++;
        $display("FAIL bp_drain%0d: got v=%b pc=%h inst=%h want v=1 pc=%h", i, InstValidOut, InstAddrOut, InstOut, 64'(4 * i));
      end
    end
  endtask

  task automatic test_flush_full;
    @(posedge Clk);
    #1 InstReadyIn = 1'b0;
    repeat (8) @(negedge Clk);
    vecs++; if (RomReadEnableOut !== 1'b0 || InstValidOut !== 1'b1) begin errs++; $display("FAIL ff_full: got en=%b v=%b want en=0 v=1", RomReadEnableOut, InstValidOut); end
    @(posedge Clk);
    #1 begin JumpFlagIn = 1'b1; JumpAddrIn = 64'h100; end
    @(negedge Clk);
    vecs++; if (RomReadEnableOut !== 1'b0) begin errs++; $display("FAIL ff_jump_en: got %b want 0", RomReadEnableOut); end
    @(posedge Clk);
    #1 JumpFlagIn = 1'b0;
    @(negedge Clk);
    vecs++; if (InstValidOut !== 1'b0) begin errs++; $display("FAIL ff_flushed: got v=%b want 0", InstValidOut); end
    vecs++; if (RomReadEnableOut !== 1'b1 || RomReadAddrOut !== 64'h100) begin errs++; $display("FAIL ff_target_req: got en=%b addr=%h want en=1 addr=100", RomReadEnableOut, RomReadAddrOut); end
    @(negedge Clk);
    vecs++; if (InstValidOut !== 1'b0) begin errs++; $display("FAIL ff_t2_valid: got %b want 0", InstValidOut); end
    @(posedge Clk);
    #1 InstReadyIn = 1'b1;
    @(negedge Clk);
    vecs++; if (InstValidOut !== 1'b1 || InstAddrOut !== 64'h100 || InstOut !== rom_word(64'h100)) begin errs++; $display("FAIL ff_t3: got v=%b pc=%h inst=%h want v=1 pc=100", InstValidOut, InstAddrOut, InstOut); end
    @(negedge Clk);
    vecs++; if (InstValidOut !== 1'b1 || InstAddrOut !== 64'h104) begin errs++; $display("FAIL ff_t4: got v=%b pc=%h want v=1 pc=104", InstValidOut, InstAddrOut); end
  endtask

  task automatic test_jump_coincident;
    repeat (3) @(negedge Clk);
    @(posedge Clk);
    #1 begin JumpFlagIn = 1'b1; JumpAddrIn = 64'h200; end
    @(negedge Clk);
    vecs++; if (RomReadyIn !== 1'b1 || InstValidOut !== 1'b1) begin errs++; $display("FAIL jc_setup: got ready=%b v=%b want 1 1", RomReadyIn, InstValidOut); end
    vecs++; if (RomReadEnableOut !== 1'b0) begin errs++; $display("FAIL jc_en: got %b want 0", RomReadEnableOut); end
    @(posedge Clk);
    #1 JumpFlagIn = 1'b0;
    @(negedge Clk);
    vecs++; if (InstValidOut !== 1'b0 || RomReadAddrOut !== 64'h200) begin errs++; $display("FAIL jc_t1: got v=%b addr=%h want v=0 addr=200", InstValidOut, RomReadAddrOut); end
    @(negedge Clk);
    vecs++; if (InstValidOut !== 1'b0) begin errs++; $display("FAIL jc_t2: got v=%b want 0", InstValidOut); end
    @(negedge Clk);
    vecs++; if (InstValidOut !== 1'b1 || InstAddrOut !== 64'h200 || InstOut !== rom_word(64'h200)) begin errs++; $display("FAIL jc_t3: got v=%b pc=%h inst=%h want v=1 pc=200", InstValidOut, InstAddrOut, InstOut); end
    @(negedge Clk);
    vecs++; if (InstAddrOut !== 64'h204) begin errs++; $display("FAIL jc_t4: got pc=%h want 204", InstAddrOut); end
  endtask

  task automatic test_misalign;
    @(posedge Clk);
    #1 begin JumpFlagIn = 1'b1; JumpAddrIn = 64'h102; end
    @(posedge Clk);
    #1 JumpFlagIn = 1'b0;
    @(negedge Clk);
`ifdef IFU_MISALIGN_CHECK_EN
    vecs++; if (AddrMisalignOut !== 1'b1) begin errs++; $display("FAIL ma_flag: got %b want 1", AddrMisalignOut); end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (RomReadEnableOut !== 1'b0 || InstValidOut !== 1'b0) begin
        errs++; $display("FAIL ma_halt%0d: got en=%b v=%b want 0 0", i, RomReadEnableOut, InstValidOut);
      end
      @(negedge Clk);
    end
`else
    vecs++; if (AddrMisalignOut !== 1'b0) begin errs++; $display("FAIL ma_flag_off: got %b want 0", AddrMisalignOut); end
    vecs++; if (RomReadEnableOut !== 1'b1 || RomReadAddrOut !== 64'h102) begin errs++; $display("FAIL ma_raw_req: got en=%b addr=%h want en=1 addr=102", RomReadEnableOut, RomReadAddrOut); end
    @(negedge Clk);
    @(negedge Clk);
    vecs++; if (InstValidOut !== 1'b1 || InstAddrOut !== 64'h102 || InstOut !== rom_word(64'h102)) begin errs++; $display("FAIL ma_raw_inst: got v=%b pc=%h inst=%h want v=1 pc=102", InstValidOut, InstAddrOut, InstOut); end
`endif
    @(posedge Clk);
    #1 begin JumpFlagIn = 1'b1; JumpAddrIn = 64'h300; end
    @(posedge Clk);
    #1 JumpFlagIn = 1'b0;
    @(negedge Clk);
    vecs++; if (AddrMisalignOut !== 1'b0) begin errs++; $display("FAIL ma_clear: got %b want 0", AddrMisalignOut); end
    vecs++; if (RomReadEnableOut !== 1'b1 || RomReadAddrOut !== 64'h300) begin errs++; $display("FAIL ma_resume_req: got en=%b addr=%h want en=1 addr=300", RomReadEnableOut, RomReadAddrOut); end
    @(negedge Clk);
    @(negedge Clk);
    vecs++; if (InstValidOut !== 1'b1 || InstAddrOut !== 64'h300 || InstOut !== rom_word(64'h300)) begin errs++; $display("FAIL ma_resume_inst: got v=%b pc=%h inst=%h want v=1 pc=300", InstValidOut, InstAddrOut, InstOut); end
  endtask

  task automatic test_async_reset;
    repeat (2) @(negedge Clk);
    @(posedge Clk);
    #3 Rst = 1'b0;
    #1;
    vecs++; if (RomReadEnableOut !== 1'b0 || RomReadAddrOut !== 64'h0) begin errs++; $display("FAIL ar_req: got en=%b addr=%h want 0 0", RomReadEnableOut, RomReadAddrOut); end
    vecs++; if (InstValidOut !== 1'b0 || InstOut !== 32'h0 || InstAddrOut !== 64'h0) begin errs++; $display("FAIL ar_out: got v=%b inst=%h pc=%h want 0 0 0", InstValidOut, InstOut, InstAddrOut); end
    vecs++; if (AddrMisalignOut !== 1'b0) begin errs++; $display("FAIL ar_misalign: got %b want 0", AddrMisalignOut); end
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    vecs++; if (RomReadEnableOut !== 1'b1 || RomReadAddrOut !== 64'h0) begin errs++; $display("FAIL ar_restart_req: got en=%b addr=%h want en=1 addr=0", RomReadEnableOut, RomReadAddrOut); end
    @(negedge Clk);
    @(negedge Clk);
    vecs++; if (InstValidOut !== 1'b1 || InstAddrOut !== 64'h0 || InstOut !== rom_word(64'h0)) begin errs++; $display("FAIL ar_restart_inst: got v=%b pc=%h inst=%h want v=1 pc=0", InstValidOut, InstAddrOut, InstOut); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_backpressure();
    test_flush_full();
    test_jump_coincident();
    test_misalign();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction-fetch initiator sitting between the core's decode stage and the behavioural instruction ROM. It generates sequential word addresses, drives the ROM read-enable/address interface, captures each `RomReadyIn`-qualified response into a small prefetch FIFO, and presents instructions to decode with a valid/ready handshake. It redirects on jump/branch, flushing all prefetched and in-flight words. A compile-time option adds jump-target misalignment detection.

## Interface
- `BOOT_ADDR`, default `64'h0000_0000_0000_0000`: first fetch address after reset.
- `ADDR_W`, default 64: address width.
- `DEPTH`, default 4: prefetch FIFO entries; power of two, ≥2.
- `Clk`  in  1  single clock; all state updates on rising edge.
- `Rst`  in  1  reset; asynchronous, active-low.
- `RomReadEnableOut`  out  1  read request to ROM.
- `RomReadAddrOut`  out  ADDR_W  byte address of the requested word.
- `RomReadDataIn`  in  32  instruction word returned by ROM.
- `RomReadyIn`  in  1  ROM response valid; sampled one cycle after an enabled request.
- `JumpFlagIn`  in  1  redirect request from execute.
- `JumpAddrIn`  in  ADDR_W  redirect target.
- `InstValidOut`  out  1  FIFO head holds a valid instruction.
- `InstOut`  out  32  FIFO head instruction.
- `InstAddrOut`  out  ADDR_W  PC of `InstOut`.
- `InstReadyIn`  in  1  decode accepts the head this cycle.
- `AddrMisalignOut`  out  1  sticky misaligned-jump flag (macro-dependent).

## Operation
- States: `IDLE`, `RUN`, `HALT`. Reset enters `IDLE`; first edge with `Rst` high moves to `RUN`.
- Registers: `Pc` (next fetch address), `Pending` (request issued last cycle), FIFO storage (instruction + PC per entry), read/write pointers, `Count` (0..DEPTH, width log2(DEPTH)+1).
- Issue (combinational): `RomReadEnableOut = (State==RUN) & !JumpFlagIn & (Count + Pending < DEPTH)`; `RomReadAddrOut = Pc`. On issue, `Pc <= Pc + 4`, `Pending <= 1`; else `Pending <= 0`.
- Push: `Pending & RomReadyIn & !JumpFlagIn` writes `{RomReadDataIn, Pc_of_request}` at write pointer. Request PC is held in a one-entry register alongside `Pending`.
- `RomReadyIn` without `Pending` is ignored.
- Pop: `InstValidOut & InstReadyIn & !JumpFlagIn` advances read pointer. `InstValidOut = (Count != 0)`.
- Simultaneous push and pop: `Count` unchanged; both pointers advance.
- Jump (`JumpFlagIn=1`, state RUN): no issue, no push, no pop this cycle; next edge clears pointers and `Count`, `Pending <= 0`, `Pc <= JumpAddrIn`. A response arriving in the jump cycle is discarded.
- Jump while `Count==DEPTH` or while decode stalls: same flush; nothing is retained.
- Pointers wrap modulo DEPTH; `Pc` wraps modulo 2^ADDR_W.
- Reset asserted mid-operation: all state cleared immediately (async); no request driven while `Rst` low.

## Timing
- Reset values: `RomReadEnableOut=0`, `RomReadAddrOut=BOOT_ADDR`, `InstValidOut=0`, `InstOut=0`, `InstAddrOut=0`, `AddrMisalignOut=0`.
- Reset release edge E0 → `IDLE`→`RUN` at E1; first request during the cycle after E1 at `BOOT_ADDR`; ROM response one cycle later; `InstValidOut` rises the cycle after that (3 cycles from E1).
- Steady state with `InstReadyIn=1`: one request per cycle, one instruction per cycle.
- Jump asserted in cycle t → request to `JumpAddrIn` in t+1 → response t+2 → `InstValidOut` with target in t+3.
- FIFO never overflows: issue is suppressed whenever occupied + in-flight = DEPTH.

## Configuration
- `IFU_MISALIGN_CHECK_EN` defined: a jump with `JumpAddrIn[1:0] != 0` flushes as normal, sets `AddrMisalignOut=1`, and enters `HALT` (no requests, `InstValidOut=0`). A subsequent aligned jump clears the flag and returns to `RUN` with `Pc <= JumpAddrIn`. Reset also clears.
- Not defined: no check; `AddrMisalignOut` tied 0; `HALT` unreachable; the target is used as given (low bits passed to ROM).

## Test plan
- Boot: release `Rst`, `InstReadyIn=1`, ROM model returns addr-derived data → first enable at `0x0`, instructions at PCs 0,4,8,12 on consecutive cycles, `InstValidOut` 3 cycles after E1.
- Backpressure: `InstReadyIn=0` for 10 cycles → exactly DEPTH=4 words buffered (PCs 0..12), `RomReadEnableOut=0` while full; release → PCs 0,4,8,12,16 in order, none lost or duplicated.
- Flush while full: FIFO full, `JumpFlagIn=1`, `JumpAddrIn=0x100` → `InstValidOut=0` next cycle; next delivered PC is 0x100 at t+3, no stale PCs.
- Jump coincident with `RomReadyIn` and `InstReadyIn` → response dropped, no pop counted; next PC 0x200 delivered.
- Misaligned jump (macro on): `JumpAddrIn=0x102` → `AddrMisalignOut=1`, no requests; aligned jump `0x300` → flag clears, fetch resumes at 0x300.
- Async reset mid-stream: assert `Rst=0` between edges → outputs at reset values immediately; after release, fetch restarts at `BOOT_ADDR`.
